// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM encodings and
// the control-output bundle consumed by the ID-stage control-zeroing mux.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_e;

  localparam int unsigned ZERO_REG = 0;

  // Field order here is the bit order the ID control-zeroing mux expects.
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic flush_signal;
    logic exmem_hold;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN    = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0, flush_signal: 1'b0, exmem_hold: 1'b0};
  localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, flush_signal: 1'b0, exmem_hold: 1'b1};
  localparam ctrl_t CTRL_BRANCH = '{pc_write: 1'b1, ifid_write: 1'b0, ifid_flush: 1'b1, flush_signal: 1'b1, exmem_hold: 1'b0};
  localparam ctrl_t CTRL_BUBBLE = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, flush_signal: 1'b1, exmem_hold: 1'b0};
  localparam ctrl_t CTRL_JUMP   = '{pc_write: 1'b1, ifid_write: 1'b0, ifid_flush: 1'b1, flush_signal: 1'b0, exmem_hold: 1'b0};
  localparam ctrl_t CTRL_RESET  = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1, flush_signal: 1'b1, exmem_hold: 1'b0};

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous reset; used for the stall and
// flush statistics.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch and
// jump squashes, data-memory wait freezes, plus statistics and timeout flag.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W             = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16,
  parameter int TIMEOUT           = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             idex_mem_read,
  input  logic [REG_W-1:0] idex_rt,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             id_jump,
  input  logic             ex_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             flush_signal,
  output logic             exmem_hold,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic             mem_timeout,
  output logic [1:0]       state
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam int DCNT_W = $clog2(LOAD_STALL_CYCLES + 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic              mem_timeout_q, mem_timeout_d;
  ctrl_t             ctrl;
  ctrl_t             ctrl_out;
  logic              stall_inc;
  logic              flush_inc;
  logic              hz;
  logic              mem_stall;
  logic              run_rules;

  assign hz = idex_mem_read && (idex_rt != REG_W'(ZERO_REG)) &&
              ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
  assign mem_stall = dmem_req && !dmem_ready;

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    dcnt_d        = dcnt_q;
    ctrl          = CTRL_RUN;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    run_rules     = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_stall) begin
          ctrl       = CTRL_FREEZE;
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end else begin
          run_rules = 1'b1;
        end
      end
      LOAD_STALL: begin
        // EX holds a bubble here, so a branch-taken indication is stale.
        if (mem_stall) begin
          ctrl = CTRL_FREEZE;
        end else begin
          ctrl      = CTRL_BUBBLE;
          stall_inc = 1'b1;
          dcnt_d    = dcnt_q - 1'b1;
          if (dcnt_q <= DCNT_W'(1)) begin
            state_d = RUN;
          end
        end
      end
      MEM_WAIT: begin
        if (!dmem_ready) begin
          ctrl = CTRL_FREEZE;
          if (wait_cnt_q != WAIT_W'(TIMEOUT)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end else begin
          run_rules = 1'b1;
        end
      end
      default: begin
        ctrl    = CTRL_FREEZE;
        state_d = RUN;
      end
    endcase

    if (run_rules) begin
      state_d = RUN;
      if (ex_branch_taken) begin
        ctrl      = CTRL_BRANCH;
        flush_inc = 1'b1;
      end else if (hz) begin
        ctrl      = CTRL_BUBBLE;
        stall_inc = 1'b1;
        if (LOAD_STALL_CYCLES > 1) begin
          state_d = LOAD_STALL;
          dcnt_d  = DCNT_W'(LOAD_STALL_CYCLES - 1);
        end
      end else if (id_jump) begin
        ctrl      = CTRL_JUMP;
        flush_inc = 1'b1;
      end
    end

    mem_timeout_d = mem_timeout_q ||
                    ((state_d == MEM_WAIT) && (wait_cnt_d == WAIT_W'(TIMEOUT)));

    ctrl_out = rst ? CTRL_RESET : ctrl;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      dcnt_q        <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      dcnt_q        <= dcnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_count)
  );

  assign pc_write     = ctrl_out.pc_write;
  assign ifid_write   = ctrl_out.ifid_write;
  assign ifid_flush   = ctrl_out.ifid_flush;
  assign flush_signal = ctrl_out.flush_signal;
  assign exmem_hold   = ctrl_out.exmem_hold;
  assign mem_timeout  = mem_timeout_q;
  assign state        = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; a second instance with 2-bit
// counters exercises statistics saturation.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       idex_mem_read = 1'b0;
  logic [4:0] idex_rt = '0;
  logic [4:0] ifid_rs = '0;
  logic [4:0] ifid_rt = '0;
  logic       ifid_uses_rt = 1'b0;
  logic       id_jump = 1'b0;
  logic       ex_branch_taken = 1'b0;
  logic       dmem_req = 1'b0;
  logic       dmem_ready = 1'b0;

  logic        pc_write, ifid_write, ifid_flush, flush_signal, exmem_hold, mem_timeout;
  logic [15:0] stall_count, flush_count;
  logic [1:0]  state;

  logic        s_pc_write, s_ifid_write, s_ifid_flush, s_flush_signal, s_exmem_hold, s_mem_timeout;
  logic [1:0]  s_stall_count, s_flush_count;
  logic [1:0]  s_state;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_W(5), .LOAD_STALL_CYCLES(2), .CNT_W(16), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .id_jump(id_jump), .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req),
    .dmem_ready(dmem_ready), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .flush_signal(flush_signal), .exmem_hold(exmem_hold),
    .stall_count(stall_count), .flush_count(flush_count), .mem_timeout(mem_timeout),
    .state(state)
  );

  pipeline_hazard_ctrl #(.REG_W(5), .LOAD_STALL_CYCLES(2), .CNT_W(2), .TIMEOUT(8)) dut_sat (
    .clk(clk), .rst(rst), .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .id_jump(id_jump), .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req),
    .dmem_ready(dmem_ready), .pc_write(s_pc_write), .ifid_write(s_ifid_write),
    .ifid_flush(s_ifid_flush), .flush_signal(s_flush_signal), .exmem_hold(s_exmem_hold),
    .stall_count(s_stall_count), .flush_count(s_flush_count), .mem_timeout(s_mem_timeout),
    .state(s_state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
    $display("check %-22s observed=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state, sampled after a clock edge with rst held high
    tick();
    chk("rst_pc_write", 32'(pc_write), 32'd0);
    chk("rst_ifid_write", 32'(ifid_write), 32'd0);
    chk("rst_ifid_flush", 32'(ifid_flush), 32'd1);
    chk("rst_flush_signal", 32'(flush_signal), 32'd1);
    chk("rst_exmem_hold", 32'(exmem_hold), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_stall_count", 32'(stall_count), 32'd0);
    chk("rst_flush_count", 32'(flush_count), 32'd0);
    chk("rst_mem_timeout", 32'(mem_timeout), 32'd0);

    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_pc_write", 32'(pc_write), 32'd1);
    chk("idle_ifid_write", 32'(ifid_write), 32'd1);
    chk("idle_flush_signal", 32'(flush_signal), 32'd0);
    tick();

    // register 0 never stalls
    idex_mem_read = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0;
    #1;
    chk("r0_pc_write", 32'(pc_write), 32'd1);
    chk("r0_flush_signal", 32'(flush_signal), 32'd0);
    tick();
    chk("r0_stall_count", 32'(stall_count), 32'd0);
    chk("r0_state", 32'(state), 32'd0);

    // load-use on rt: only when ifid_uses_rt
    idex_rt = 5'd5; ifid_rs = 5'd1; ifid_rt = 5'd5; ifid_uses_rt = 1'b0;
    #1;
    chk("rt_unused_pc_write", 32'(pc_write), 32'd1);
    ifid_uses_rt = 1'b1;
    #1;
    chk("rt_used_pc_write", 32'(pc_write), 32'd0);
    ifid_uses_rt = 1'b0; ifid_rt = 5'd0;

    // load-use on rs: two bubbles
    idex_rt = 5'd3; ifid_rs = 5'd3;
    #1;
    chk("lu1_pc_write", 32'(pc_write), 32'd0);
    chk("lu1_ifid_write", 32'(ifid_write), 32'd0);
    chk("lu1_flush_signal", 32'(flush_signal), 32'd1);
    tick();
    chk("lu2_state", 32'(state), 32'd1);
    chk("lu2_stall_count", 32'(stall_count), 32'd1);
    chk("lu2_pc_write", 32'(pc_write), 32'd0);
    chk("lu2_flush_signal", 32'(flush_signal), 32'd1);
    tick();
    chk("lu_done_state", 32'(state), 32'd0);
    chk("lu_done_stall_count", 32'(stall_count), 32'd2);
    idex_mem_read = 1'b0;
    #1;
    chk("lu_done_pc_write", 32'(pc_write), 32'd1);

    // branch and jump together count once
    ex_branch_taken = 1'b1; id_jump = 1'b1;
    #1;
    chk("bj_pc_write", 32'(pc_write), 32'd1);
    chk("bj_ifid_flush", 32'(ifid_flush), 32'd1);
    chk("bj_flush_signal", 32'(flush_signal), 32'd1);
    tick();
    chk("bj_flush_count", 32'(flush_count), 32'd1);
    ex_branch_taken = 1'b0;

    // jump only
    #1;
    chk("j_pc_write", 32'(pc_write), 32'd1);
    chk("j_ifid_flush", 32'(ifid_flush), 32'd1);
    chk("j_flush_signal", 32'(flush_signal), 32'd0);
    tick();
    chk("j_flush_count", 32'(flush_count), 32'd2);
    id_jump = 1'b0;

    // branch has priority over a load-use hazard
    idex_mem_read = 1'b1; idex_rt = 5'd7; ifid_rs = 5'd7; ex_branch_taken = 1'b1;
    #1;
    chk("bprio_pc_write", 32'(pc_write), 32'd1);
    tick();
    chk("bprio_flush_count", 32'(flush_count), 32'd3);
    chk("bprio_stall_count", 32'(stall_count), 32'd2);
    chk("bprio_state", 32'(state), 32'd0);
    idex_mem_read = 1'b0; ex_branch_taken = 1'b0; id_jump = 1'b1;
    tick();
    chk("sat_flush_main", 32'(flush_count), 32'd4);
    chk("sat_flush_2bit", 32'(s_flush_count), 32'd3);
    id_jump = 1'b0;

    // memory wait of 4 cycles
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("mw_hold_%0d", i), 32'(exmem_hold), 32'd1);
      chk($sformatf("mw_pc_write_%0d", i), 32'(pc_write), 32'd0);
      tick();
    end
    chk("mw_state", 32'(state), 32'd2);
    dmem_ready = 1'b1;
    #1;
    chk("mw_ready_hold", 32'(exmem_hold), 32'd0);
    chk("mw_ready_pc_write", 32'(pc_write), 32'd1);
    chk("mw_ready_ifid_write", 32'(ifid_write), 32'd1);
    tick();
    chk("mw_done_state", 32'(state), 32'd0);
    chk("mw_done_timeout", 32'(mem_timeout), 32'd0);
    dmem_req = 1'b0; dmem_ready = 1'b0;

    // memory freeze inside LOAD_STALL does not consume a bubble
    idex_mem_read = 1'b1; idex_rt = 5'd9; ifid_rs = 5'd9;
    tick();
    chk("lsf_state", 32'(state), 32'd1);
    chk("lsf_stall_count", 32'(stall_count), 32'd3);
    dmem_req = 1'b1;
    #1;
    chk("lsf_hold", 32'(exmem_hold), 32'd1);
    tick();
    chk("lsf_frozen_state", 32'(state), 32'd1);
    chk("lsf_frozen_stall", 32'(stall_count), 32'd3);
    dmem_req = 1'b0;
    tick();
    chk("lsf_done_state", 32'(state), 32'd0);
    chk("lsf_done_stall", 32'(stall_count), 32'd4);
    chk("sat_stall_2bit", 32'(s_stall_count), 32'd3);
    idex_mem_read = 1'b0;

    // timeout after 8 wait cycles, sticky past ready
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("to_cycle_%0d", k), 32'(mem_timeout), (k >= 8) ? 32'd1 : 32'd0);
    end
    dmem_ready = 1'b1;
    tick();
    chk("to_after_ready_state", 32'(state), 32'd0);
    chk("to_after_ready_flag", 32'(mem_timeout), 32'd1);
    dmem_req = 1'b0; dmem_ready = 1'b0;

    // asynchronous reset mid-LOAD_STALL
    idex_mem_read = 1'b1; idex_rt = 5'd4; ifid_rs = 5'd4;
    tick();
    chk("ar_pre_state", 32'(state), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_state", 32'(state), 32'd0);
    chk("ar_stall_count", 32'(stall_count), 32'd0);
    chk("ar_flush_count", 32'(flush_count), 32'd0);
    chk("ar_mem_timeout", 32'(mem_timeout), 32'd0);
    chk("ar_pc_write", 32'(pc_write), 32'd0);
    chk("ar_ifid_flush", 32'(ifid_flush), 32'd1);
    idex_mem_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("ar_post_state", 32'(state), 32'd0);
    chk("ar_post_pc_write", 32'(pc_write), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
